imem_loader: RTL and testbench

Boot-time loader that writes a program image into instruction memory before the pipelined datapath starts fetching. It accepts a length-prefixed byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit words, and issues one-cycle word writes at byte addresses 0, 4, 8, and so on, matching PC increments of 4. While loading, it holds the CPU (PC and pipeline registers) and releases it on successful completion.

---
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into instruction memory as big-endian words.
// Optional trailer checksum is compiled in when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] word_count
);
    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t FINISH = CHK;
`else
    localparam state_t FINISH = DONE;
`endif

    state_t            r_state;
    state_t            w_nxt;
    logic [15:0]       r_len;
    logic [23:0]       r_shift;
    logic [1:0]        r_idx;
    logic              w_xfer;
    logic [15:0]       w_len;
    logic [15:0]       w_cnt_inc;
    logic [ADDR_W+1:0] w_addr_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    assign w_xfer     = byte_valid & byte_ready;
    assign w_len      = {r_len[15:8], byte_in};
    assign w_cnt_inc  = word_count + 16'd1;
    assign w_addr_inc = wr_addr[ADDR_W+1:0] + (ADDR_W+2)'(4);

    function automatic logic is_recv(input state_t s);
        logic r;
        r = (s == LEN_HI) || (s == LEN_LO) || (s == DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        r = r || (s == CHK);
`endif
        return r;
    endfunction

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE, DONE, ERR: if (start) w_nxt = LEN_HI;
            LEN_HI:          if (w_xfer) w_nxt = LEN_LO;
            LEN_LO: begin
                if (w_xfer) begin
                    if (w_len == 16'd0)                w_nxt = FINISH;
                    else if ({1'b0, w_len} > MAX_WORDS) w_nxt = ERR;
                    else                                w_nxt = DATA;
                end
            end
            DATA:            if (w_xfer && (r_idx == 2'd3)) w_nxt = WRITE;
            WRITE:           w_nxt = (w_cnt_inc == r_len) ? FINISH : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:             if (w_xfer) w_nxt = (byte_in == r_csum) ? DONE : ERR;
`endif
            default:         w_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            r_idx      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_state    <= w_nxt;
            byte_ready <= is_recv(w_nxt);
            wr_en      <= (w_nxt == WRITE);
            busy       <= !((w_nxt == IDLE) || (w_nxt == DONE) || (w_nxt == ERR));
            done       <= (w_nxt == DONE);
            err        <= (w_nxt == ERR);
            cpu_hold   <= (w_nxt != DONE);
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        word_count <= '0;
                        wr_addr    <= '0;
                        r_idx      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum     <= '0;
`endif
                    end
                end
                LEN_HI: if (w_xfer) r_len[15:8] <= byte_in;
                LEN_LO: if (w_xfer) r_len[7:0]  <= byte_in;
                DATA: begin
                    if (w_xfer) begin
                        r_shift <= {r_shift[15:0], byte_in};
                        r_idx   <= r_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum  <= r_csum ^ byte_in;
`endif
                        if (r_idx == 2'd3) wr_data <= {r_shift, byte_in};
                    end
                end
                // Address wraps within the memory span; the length check keeps writes in range.
                WRITE: begin
                    wr_addr    <= 32'(w_addr_inc);
                    word_count <= w_cnt_inc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized image loads checked against a queue-based model of expected writes.
module tb_imem_loader;
    localparam int ADDR_W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] cnt;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e_cur;
    int          n_checks = 0;
    int          n_errs = 0;
    int          n_wr = 0;
    logic [31:0] last_addr = 32'h0;
    bit          mon_en = 1'b0;
    logic        prev_wr = 1'b0;
    logic [7:0]  pay [0:1023];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare process
    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_en) begin
                n_wr++;
                chk1("ready_low_in_write", byte_ready, 1'b0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL unexpected_write: got addr %h data %h, required no write", wr_addr, wr_data);
                end else begin
                    e_cur = exp_q.pop_front();
                    chk32("wr_addr", wr_addr, e_cur.addr);
                    chk32("wr_data", wr_data, e_cur.data);
                    chk32("word_count_at_write", {16'h0, word_count}, {16'h0, e_cur.cnt});
                    last_addr = wr_addr;
                end
            end
            chk1("wr_en_back_to_back", wr_en & prev_wr, 1'b0);
            chk1("hold_vs_done", cpu_hold, !done);
            chk1("done_err_exclusive", done & err, 1'b0);
            chk1("busy_vs_levels", busy & (done | err), 1'b0);
            prev_wr = wr_en;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int gap_for(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            rdy = byte_ready;
            tick();
            if (rdy) begin
                byte_valid = 1'b0;
                return;
            end
        end
        byte_valid = 1'b0;
        n_checks++;
        n_errs++;
        $display("FAIL byte_accept_timeout: got no byte_ready, required acceptance of %h", b);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end();
        for (int t = 0; t < 100; t++) begin
            if (done || err) return;
            tick();
        end
        n_checks++;
        n_errs++;
        $display("FAIL end_timeout: got done=%b err=%b, required one of them high", done, err);
    endtask

    function automatic logic [7:0] csum_of(input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 4 * n; i++) c = c ^ pay[10'(i)];
        return c;
    endfunction

    task automatic push_model(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(wr_t'{32'(4 * i),
                                  {pay[10'(4*i)], pay[10'(4*i+1)], pay[10'(4*i+2)], pay[10'(4*i+3)]},
                                  16'(i)});
    endtask

    task automatic do_load(input int n, input int mode, input logic [7:0] trailer, input logic ok);
        int          w0;
        logic [15:0] nn;
        w0 = n_wr;
        nn = 16'(n);
        $display("load: n=%0d mode=%0d trailer=%h", n, mode, trailer);
        pulse_start();
        chk1("busy_after_start", busy, 1'b1);
        chk1("done_cleared", done, 1'b0);
        chk1("err_cleared", err, 1'b0);
        chk1("hold_after_start", cpu_hold, 1'b1);
        chk32("count_cleared", {16'h0, word_count}, 32'h0);
        send_byte(nn[15:8], gap_for(mode));
        send_byte(nn[7:0], gap_for(mode));
        for (int i = 0; i < 4 * n; i++) send_byte(pay[10'(i)], gap_for(mode));
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(trailer, gap_for(mode));
`endif
        wait_end();
        chk1("done_level", done, ok);
        chk1("err_level", err, !ok);
        chk1("hold_level", cpu_hold, !ok);
        chk1("busy_idle", busy, 1'b0);
        chk32("word_count_final", {16'h0, word_count}, 32'(n));
        chk32("write_pulses", 32'(n_wr - w0), 32'(n));
        chk32("pending_writes", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic load_demo_bytes();
        pay[0] = 8'h20; pay[1] = 8'h08; pay[2] = 8'h00; pay[3] = 8'h05;
        pay[4] = 8'h8C; pay[5] = 8'h01; pay[6] = 8'h00; pay[7] = 8'h04;
    endtask

    initial begin
        int   n;
        int   mode;
        int   w0;
        logic bad;
        logic [7:0] tr;

        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        tick();
        tick();
        chk1("rst_cpu_hold", cpu_hold, 1'b1);
        chk1("rst_byte_ready", byte_ready, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_wr_en", wr_en, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_word_count", {16'h0, word_count}, 32'h0);
        chk32("rst_wr_addr", wr_addr, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Two-word image with hand-derived writes; 0xA4 is the XOR of the eight payload bytes.
        load_demo_bytes();
        exp_q.push_back(wr_t'{32'h0, 32'h20080005, 16'd0});
        exp_q.push_back(wr_t'{32'h4, 32'h8C010004, 16'd1});
        do_load(2, 0, 8'hA4, 1'b1);

        // Same image, source valid toggling every other cycle
        exp_q.push_back(wr_t'{32'h0, 32'h20080005, 16'd0});
        exp_q.push_back(wr_t'{32'h4, 32'h8C010004, 16'd1});
        do_load(2, 1, 8'hA4, 1'b1);

        // Oversized length: error with no writes
        w0 = n_wr;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        wait_end();
        chk1("oversize_err", err, 1'b1);
        chk1("oversize_done", done, 1'b0);
        chk1("oversize_hold", cpu_hold, 1'b1);
        chk32("oversize_writes", 32'(n_wr - w0), 32'h0);

        // Zero length
        do_load(0, 0, 8'h00, 1'b1);

        // Full-depth image
        for (int i = 0; i < 1024; i++) pay[10'(i)] = 8'($urandom);
        push_model(256);
        do_load(256, 0, csum_of(256), 1'b1);
        chk32("last_write_addr", last_addr, 32'h3FC);

        // Reset in the middle of the first word
        w0 = n_wr;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_ready", byte_ready, 1'b0);
        chk1("midrst_done", done, 1'b0);
        chk1("midrst_hold", cpu_hold, 1'b1);
        chk32("midrst_count", {16'h0, word_count}, 32'h0);
        tick();
        tick();
        chk32("midrst_writes", 32'(n_wr - w0), 32'h0);
        load_demo_bytes();
        push_model(2);
        do_load(2, 2, csum_of(2), 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong trailer on a one-word image
        for (int i = 0; i < 4; i++) pay[10'(i)] = 8'($urandom);
        push_model(1);
        do_load(1, 0, csum_of(1) ^ 8'h5A, 1'b0);
`endif

        // Randomized images, lengths and source throttling
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 12));
            mode = int'($urandom_range(0, 2));
            for (int i = 0; i < 4 * n; i++) pay[10'(i)] = 8'($urandom);
            bad = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            bad = ($urandom_range(0, 2) == 0);
`endif
            tr = csum_of(n) ^ (bad ? 8'h5A : 8'h00);
            push_model(n);
            do_load(n, mode, tr, !bad);
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
